// File: rtl/keycode_packer_if.sv
// Key-event handshake between an event source (master) and the keycode packer (slave).
// An event transfers on a rising clock edge where ev_valid and ev_ready are both high.
interface keycode_packer_if #(
  parameter int CODE_W = 8
);
  logic              ev_valid;
  logic              ev_ready;
  logic [CODE_W-1:0] ev_code;
  logic              ev_make;

  modport master (output ev_valid, output ev_code, output ev_make, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_make, output ev_ready);
endinterface

// File: rtl/keycode_packer.sv
// Packs a stream of key press/release events into a duplicate-free, left-compacted
// NUM_SLOTS x CODE_W keycode vector and strobes report_valid whenever the vector changes.
module keycode_packer #(
  parameter int NUM_SLOTS = 4,
  parameter int CODE_W    = 8,
  localparam int CNT_W    = $clog2(NUM_SLOTS + 1),
  localparam int IDX_W    = $clog2(NUM_SLOTS)
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  keycode_packer_if.slave             ev,
  input  logic                        clear,
  output logic [NUM_SLOTS*CODE_W-1:0] keycode,
  output logic                        report_valid,
  output logic                        overflow,
  output logic [CNT_W-1:0]            count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_APPLY   = 2'd1,
    S_COMPACT = 2'd2,
    S_REPORT  = 2'd3
  } state_e;

  typedef logic [NUM_SLOTS-1:0][CODE_W-1:0] table_t;

  state_e                      state_q, state_d;
  table_t                      tbl_q, tbl_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CODE_W-1:0]           code_q, code_d;
  logic                        make_q, make_d;
  logic [NUM_SLOTS*CODE_W-1:0] keycode_q, keycode_d;
  logic                        report_q, report_d;
  logic                        ovf_s;
  logic [IDX_W:0]              found_s;
  logic                        hit_s;
  logic [IDX_W-1:0]            hidx_s;
  logic [IDX_W-1:0]            idx_nxt_s;

  // Returns {hit, lowest matching slot}; empty slots hold 00 and code 00 is filtered earlier.
  function automatic logic [IDX_W:0] find_slot(input table_t t, input logic [CODE_W-1:0] c);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (t[i] == c) begin
        r = {1'b1, IDX_W'(i)};
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign found_s   = find_slot(tbl_q, code_q);
  assign hit_s     = found_s[IDX_W];
  assign hidx_s    = found_s[IDX_W-1:0];
  assign idx_nxt_s = idx_q + IDX_W'(1);

  assign ev.ev_ready  = Reset_n & (state_q == S_IDLE) & ~clear;
  assign keycode      = keycode_q;
  assign report_valid = report_q;
  assign overflow     = ovf_s;
  assign count        = count_q;

  // Next-state, slot-table and output-register computation.
  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    count_d = count_q;
    idx_d   = idx_q;
    code_d  = code_q;
    make_d  = make_q;
    ovf_s   = 1'b0;

    if (clear) begin
      // Flush wins over everything, including an overflow decided in this same cycle.
      tbl_d   = '0;
      count_d = '0;
      idx_d   = '0;
      state_d = S_REPORT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ev.ev_valid) begin
            code_d  = ev.ev_code;
            make_d  = ev.ev_make;
            state_d = S_APPLY;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_APPLY: begin
          if (code_q == CODE_W'(0)) begin
            state_d = S_IDLE;
          end else if (make_q) begin
            if (hit_s) begin
              state_d = S_IDLE;
            end else if (count_q < CNT_W'(NUM_SLOTS)) begin
              tbl_d[count_q[IDX_W-1:0]] = code_q;
              count_d = count_q + CNT_W'(1);
              state_d = S_REPORT;
            end else begin
              ovf_s   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            if (!hit_s) begin
              state_d = S_IDLE;
            end else begin
              tbl_d[hidx_s] = CODE_W'(0);
              count_d = count_q - CNT_W'(1);
              idx_d   = hidx_s;
              // Releasing the last occupied slot leaves nothing to close up.
              if (CNT_W'(hidx_s) == count_q - CNT_W'(1)) begin
                state_d = S_REPORT;
              end else begin
                state_d = S_COMPACT;
              end
            end
          end
        end
        S_COMPACT: begin
          // count_q already holds the post-release count, i.e. the index of the last hole.
          tbl_d[idx_q]     = tbl_q[idx_nxt_s];
          tbl_d[idx_nxt_s] = CODE_W'(0);
          idx_d            = idx_nxt_s;
          if (CNT_W'(idx_nxt_s) == count_q) begin
            state_d = S_REPORT;
          end else begin
            state_d = S_COMPACT;
          end
        end
        S_REPORT: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    report_d = (state_d == S_REPORT);
    if (report_d) begin
      keycode_d = tbl_d;
    end else begin
      keycode_d = keycode_q;
    end
  end

  // All state registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      tbl_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      code_q    <= '0;
      make_q    <= 1'b0;
      keycode_q <= '0;
      report_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tbl_q     <= tbl_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      make_q    <= make_d;
      keycode_q <= keycode_d;
      report_q  <= report_d;
    end
  end

endmodule

// File: tb/tb_keycode_packer.sv
// Directed, table-driven bench for keycode_packer: event vectors with hand-computed
// report/overflow cycles and resulting vectors, plus clear and reset corner sequences.
module tb_keycode_packer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [31:0] keycode;
  logic        report_valid;
  logic        overflow;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  keycode_packer_if ev_if ();

  keycode_packer dut (
    .Clk          (clk),
    .Reset_n      (rst_n),
    .ev           (ev_if),
    .clear        (clear),
    .keycode      (keycode),
    .report_valid (report_valid),
    .overflow     (overflow),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp_rep / exp_ovf: cycle index after the accept edge (1 = first cycle after it), 0 = never
  typedef struct {
    logic [7:0]  code;
    logic        make;
    logic [31:0] exp_key;
    logic [2:0]  exp_cnt;
    int          exp_rep;
    int          exp_ovf;
  } vec_t;

  vec_t vecs [0:21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one event and returns #1 after the edge where it was accepted.
  task automatic send(input logic [7:0] code, input logic make);
    int n;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_code  = code;
    ev_if.ev_make  = make;
    n = 0;
    while (!ev_if.ev_ready && n < 20) begin
      step();
      n++;
    end
    if (!ev_if.ev_ready) chk("ready_timeout", 32'd0, 32'd1);
    step();
    ev_if.ev_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t        v;
    int          rep_c, ovf_c, rdy_c, exp_rdy;
    logic [31:0] key_prev;
    logic        bad_kc;
    v = vecs[k];
    send(v.code, v.make);
    rep_c = 0; ovf_c = 0; rdy_c = 0; bad_kc = 1'b0;
    key_prev = keycode;
    for (int i = 1; i <= 12; i++) begin
      if (overflow) ovf_c = i;
      if (report_valid) rep_c = i;
      else if (keycode !== key_prev) bad_kc = 1'b1;
      key_prev = keycode;
      if (ev_if.ev_ready) begin
        rdy_c = i;
        break;
      end
      step();
    end
    exp_rdy = (v.exp_rep != 0) ? v.exp_rep + 1 : 2;
    chk($sformatf("v%0d_report_cycle", k), rep_c, v.exp_rep);
    chk($sformatf("v%0d_overflow_cycle", k), ovf_c, v.exp_ovf);
    chk($sformatf("v%0d_ready_cycle", k), rdy_c, exp_rdy);
    chk($sformatf("v%0d_keycode", k), keycode, v.exp_key);
    chk($sformatf("v%0d_count", k), {29'd0, count}, {29'd0, v.exp_cnt});
    chk($sformatf("v%0d_keycode_stable", k), {31'd0, bad_kc}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{8'h04, 1'b1, 32'h0000_0004, 3'd1, 2, 0};
    vecs[1]  = '{8'h07, 1'b1, 32'h0000_0704, 3'd2, 2, 0};
    vecs[2]  = '{8'h0A, 1'b1, 32'h000A_0704, 3'd3, 2, 0};
    vecs[3]  = '{8'h0B, 1'b1, 32'h0B0A_0704, 3'd4, 2, 0};
    vecs[4]  = '{8'h28, 1'b1, 32'h0B0A_0704, 3'd4, 0, 1};  // table full
    vecs[5]  = '{8'h07, 1'b0, 32'h000B_0A04, 3'd3, 4, 0};  // slot 1 of 4
    vecs[6]  = '{8'h04, 1'b1, 32'h000B_0A04, 3'd3, 0, 0};  // already held
    vecs[7]  = '{8'h59, 1'b0, 32'h000B_0A04, 3'd3, 0, 0};  // not held
    vecs[8]  = '{8'h00, 1'b1, 32'h000B_0A04, 3'd3, 0, 0};  // null code
    vecs[9]  = '{8'h0B, 1'b0, 32'h0000_0A04, 3'd2, 2, 0};  // last slot
    vecs[10] = '{8'h04, 1'b0, 32'h0000_000A, 3'd1, 3, 0};
    vecs[11] = '{8'h0A, 1'b0, 32'h0000_0000, 3'd0, 2, 0};
    vecs[12] = '{8'h11, 1'b1, 32'h0000_0011, 3'd1, 2, 0};
    vecs[13] = '{8'h22, 1'b1, 32'h0000_2211, 3'd2, 2, 0};
    vecs[14] = '{8'h33, 1'b1, 32'h0033_2211, 3'd3, 2, 0};
    vecs[15] = '{8'h44, 1'b1, 32'h4433_2211, 3'd4, 2, 0};
    vecs[16] = '{8'h11, 1'b0, 32'h0044_3322, 3'd3, 5, 0};  // slot 0 of 4
    vecs[17] = '{8'h55, 1'b1, 32'h5544_3322, 3'd4, 2, 0};
    vecs[18] = '{8'h01, 1'b1, 32'h0000_0001, 3'd1, 2, 0};
    vecs[19] = '{8'h02, 1'b1, 32'h0000_0201, 3'd2, 2, 0};
    vecs[20] = '{8'h03, 1'b1, 32'h0003_0201, 3'd3, 2, 0};
    vecs[21] = '{8'h66, 1'b1, 32'h0000_0066, 3'd1, 2, 0};

    rst_n = 1'b0;
    clear = 1'b0;
    ev_if.ev_valid = 1'b0;
    ev_if.ev_code  = 8'h00;
    ev_if.ev_make  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_keycode", keycode, 32'h0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_report", {31'd0, report_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_ready", {31'd0, ev_if.ev_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {31'd0, ev_if.ev_ready}, 32'd1);

    for (int k = 0; k <= 17; k++) run_vec(k);

    // Overflow and clear in the same APPLY cycle: clear wins, no overflow pulse.
    send(8'h66, 1'b1);
    clear = 1'b1;
    #1;
    chk("clr_ovf_overflow", {31'd0, overflow}, 32'd0);
    chk("clr_ovf_ready", {31'd0, ev_if.ev_ready}, 32'd0);
    step();
    clear = 1'b0;
    chk("clr_ovf_report", {31'd0, report_valid}, 32'd1);
    chk("clr_ovf_keycode", keycode, 32'h0);
    chk("clr_ovf_count", {29'd0, count}, 32'd0);
    step();
    chk("clr_ovf_report_end", {31'd0, report_valid}, 32'd0);
    chk("clr_ovf_ready_back", {31'd0, ev_if.ev_ready}, 32'd1);

    for (int k = 18; k <= 20; k++) run_vec(k);

    // Clear during COMPACT: release slot 0 of 3, flush in the first shift cycle.
    send(8'h01, 1'b0);
    step();
    chk("cmp_ready_low", {31'd0, ev_if.ev_ready}, 32'd0);
    chk("cmp_no_report", {31'd0, report_valid}, 32'd0);
    chk("cmp_keycode_held", keycode, 32'h0003_0201);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("cmp_clr_report", {31'd0, report_valid}, 32'd1);
    chk("cmp_clr_keycode", keycode, 32'h0);
    chk("cmp_clr_count", {29'd0, count}, 32'd0);
    step();
    chk("cmp_clr_report_end", {31'd0, report_valid}, 32'd0);
    step();
    chk("cmp_clr_no_stray", {31'd0, report_valid}, 32'd0);
    chk("cmp_clr_keycode_end", keycode, 32'h0);

    // Clear on an empty table still reports; a concurrent event is not accepted.
    ev_if.ev_valid = 1'b1;
    ev_if.ev_code  = 8'h12;
    ev_if.ev_make  = 1'b1;
    clear = 1'b1;
    #1;
    chk("eclr_ready_low", {31'd0, ev_if.ev_ready}, 32'd0);
    step();
    clear = 1'b0;
    ev_if.ev_valid = 1'b0;
    chk("eclr_report", {31'd0, report_valid}, 32'd1);
    chk("eclr_keycode", keycode, 32'h0);
    repeat (3) step();
    chk("eclr_event_dropped", {29'd0, count}, 32'd0);
    chk("eclr_no_report", {31'd0, report_valid}, 32'd0);

    run_vec(21);

    // Reset during APPLY of a press.
    send(8'h77, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mrst_keycode", keycode, 32'h0);
    chk("mrst_count", {29'd0, count}, 32'd0);
    chk("mrst_ready", {31'd0, ev_if.ev_ready}, 32'd0);
    chk("mrst_report", {31'd0, report_valid}, 32'd0);
    step();
    step();
    chk("mrst_ready_held", {31'd0, ev_if.ev_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_ready_back", {31'd0, ev_if.ev_ready}, 32'd1);
    step();
    chk("mrst_no_report", {31'd0, report_valid}, 32'd0);
    chk("mrst_keycode_end", keycode, 32'h0);
    chk("mrst_count_end", {29'd0, count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
